// File: rtl/inv_distributor_pkg.sv
// Shared types for the invalidation distributor and its arbiter.
package inv_distributor_pkg;
  localparam int INV_ADDR_W = 30;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMPLETE} inv_dist_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/inv_distributor_if.sv
// Source-side and sink-side invalidation bus; master is the distributor.
interface inv_distributor_if
  import inv_distributor_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int NUM_SINKS   = 2
);
  logic [NUM_SOURCES-1:0][INV_ADDR_W-1:0] src_inv_addr;
  logic [NUM_SOURCES-1:0]                 src_inv_valid;
  logic [NUM_SOURCES-1:0]                 src_inv_completed;
  logic [INV_ADDR_W-1:0]                  snk_inv_addr;
  logic [NUM_SINKS-1:0]                   snk_inv_valid;
  logic [NUM_SINKS-1:0]                   snk_inv_ready;
  logic [NUM_SINKS-1:0]                   snk_inv_outstanding;

  modport master (
    input  src_inv_addr, src_inv_valid, snk_inv_ready, snk_inv_outstanding,
    output src_inv_completed, snk_inv_addr, snk_inv_valid
  );

  modport slave (
    output src_inv_addr, src_inv_valid, snk_inv_ready, snk_inv_outstanding,
    input  src_inv_completed, snk_inv_addr, snk_inv_valid
  );
endinterface

// File: rtl/inv_distributor_rr_arbiter.sv
// Combinational round-robin pick: first request after last_grant_i, wrapping.
module inv_rr_arbiter #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_grant_i,
  output logic [GW-1:0] grant_o,
  output logic          grant_vld_o
);
  logic [GW-1:0] idx;

  // Walk from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant_o     = '0;
    grant_vld_o = 1'b0;
    idx         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = GW'((int'(last_grant_i) + i) % N);
      if (req_i[idx]) begin
        grant_o     = idx;
        grant_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/inv_distributor.sv
// Round-robin arbitration of invalidation requests, broadcast to all sinks,
// completion pulse once every sink accepted and none is still outstanding.
module inv_distributor
  import inv_distributor_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int NUM_SINKS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  inv_distributor_if.master  bus,
  output logic               busy
);
  localparam int GW = idx_width(NUM_SOURCES);

  inv_dist_state_t         state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           last_grant_q;
  logic [INV_ADDR_W-1:0]   addr_q;
  logic [NUM_SINKS-1:0]    accepted_q;
  logic [NUM_SINKS-1:0]    accepted_d;
  logic [NUM_SINKS-1:0]    snk_vld_q;
  logic [NUM_SOURCES-1:0]  completed_q;
  logic [GW-1:0]           arb_grant;
  logic                    arb_vld;

  inv_rr_arbiter #(.N(NUM_SOURCES), .GW(GW)) u_arb (
    .req_i        (bus.src_inv_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_vld_o  (arb_vld)
  );

  assign accepted_d = accepted_q | (snk_vld_q & bus.snk_inv_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SOURCES - 1);
      addr_q       <= '0;
      accepted_q   <= '0;
      snk_vld_q    <= '0;
      completed_q  <= '0;
    end else begin
      completed_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            grant_q    <= arb_grant;
            addr_q     <= bus.src_inv_addr[arb_grant];
            accepted_q <= '0;
            snk_vld_q  <= '1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // A sink that has accepted sees valid drop from the next cycle.
          accepted_q <= accepted_d;
          snk_vld_q  <= ~accepted_d;
          if (&accepted_d) state_q <= DRAIN;
        end
        DRAIN: begin
          if (bus.snk_inv_outstanding == '0) begin
            completed_q[grant_q] <= 1'b1;
            state_q              <= COMPLETE;
          end
        end
        COMPLETE: begin
          // The still-held source valid is ignored here so it is not re-granted.
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_inv_completed = completed_q;
  assign bus.snk_inv_addr      = addr_q;
  assign bus.snk_inv_valid     = snk_vld_q;
  assign busy                  = (state_q != IDLE);
endmodule
